// File: rtl/arbitrated_memory_pkg.sv
// Shared constants and helpers for the arbitrated memory and its arbiter.
package arbitrated_memory_pkg;

  localparam int MODE_RR    = 0;
  localparam int MODE_FIXED = 1;

  localparam logic RW_READ  = 1'b0;
  localparam logic RW_WRITE = 1'b1;

  // Index width for a channel count, never narrower than one bit.
  function automatic int clog2Min1(input int value);
    return (value <= 1) ? 1 : $clog2(value);
  endfunction

endpackage

// File: rtl/arbitrated_memory_if.sv
// Request/acknowledge bus between the executors and the arbitrated memory.
//
// Handshake: Req[c] is a level. The memory samples it on a rising edge; if
// channel c wins there, Ack[c] is high for exactly the following cycle, and
// RValid/RData/AckChannel describe that completed access. A channel is never
// granted in the cycle its Ack is high, so during Ack the requester either
// drops Req or presents its next request, which is sampled on the next edge.
interface arbitrated_memory_if
  import arbitrated_memory_pkg::*;
#(
  parameter int N        = 8,
  parameter int M        = 2,
  parameter int CHANNELS = 4
) ();

  localparam int IW = clog2Min1(CHANNELS);

  logic [CHANNELS-1:0]   Req;
  logic [CHANNELS-1:0]   RW;
  logic [CHANNELS*M-1:0] Select;
  logic [CHANNELS*N-1:0] WData;
  logic [CHANNELS-1:0]   Ack;
  logic                  RValid;
  logic [N-1:0]          RData;
  logic [IW-1:0]         AckChannel;

  modport master (
    output Req, RW, Select, WData,
    input  Ack, RValid, RData, AckChannel
  );

  modport slave (
    input  Req, RW, Select, WData,
    output Ack, RValid, RData, AckChannel
  );

endinterface

// File: rtl/arbitrated_memory_rr_arbiter.sv
// Single-grant arbiter: round-robin from a rotating pointer, or fixed
// priority with the lowest index winning.
module rr_arbiter
  import arbitrated_memory_pkg::*;
#(
  parameter int CHANNELS = 4,
  parameter int MODE     = MODE_RR,
  localparam int IW      = clog2Min1(CHANNELS)
) (
  input  logic                Clock,
  input  logic                Reset,
  input  logic [CHANNELS-1:0] eligible,
  output logic [CHANNELS-1:0] grant,
  output logic [IW-1:0]       grantIdx,
  output logic                anyGrant
);

  // Last winner in round-robin mode; the search starts just above it.
  logic [IW-1:0] pointer;

  // Pick the first eligible channel in search order.
  always_comb begin
    int            cand;
    logic [IW-1:0] candIdx;
    grant    = '0;
    grantIdx = '0;
    anyGrant = 1'b0;
    cand     = 0;
    candIdx  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (MODE == MODE_RR) begin
        cand = int'(pointer) + 1 + i;
        if (cand >= CHANNELS) cand = cand - CHANNELS;
      end else begin
        cand = i;
      end
      candIdx = IW'(cand);
      if (!anyGrant && eligible[candIdx]) begin
        anyGrant = 1'b1;
        grantIdx = candIdx;
      end
    end
    grant[grantIdx] = anyGrant;
  end

  // Pointer follows the winner; starts at the top so channel 0 wins first.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      pointer <= IW'(CHANNELS - 1);
    end else if (anyGrant) begin
      pointer <= grantIdx;
    end
  end

endmodule

// File: rtl/arbitrated_memory.sv
// Shared word-addressed store serving one access per clock to CHANNELS
// requesters through the arbiter.
module arbitrated_memory
  import arbitrated_memory_pkg::*;
#(
  parameter int N        = 8,
  parameter int M        = 2,
  parameter int CHANNELS = 4,
  parameter int MODE     = MODE_RR
) (
  input logic                Clock,
  input logic                Reset,
  arbitrated_memory_if.slave bus
);

  localparam int COUNT = 2 ** M;
  localparam int IW    = clog2Min1(CHANNELS);

  logic [N-1:0]          mem [COUNT];
  logic [CHANNELS-1:0]   ackReg;
  logic [CHANNELS-1:0]   eligible;
  logic [CHANNELS-1:0]   grant;
  logic [IW-1:0]         grantIdx;
  logic                  anyGrant;
  logic [IW-1:0]         ackChannelReg;
  logic                  rValidReg;
  logic [N-1:0]          rDataReg;
  logic [M-1:0]          winAddr;
  logic [N-1:0]          winData;
  logic                  winRW;

  // A channel being acknowledged this cycle sits out one edge.
  assign eligible = bus.Req & ~ackReg;

  rr_arbiter #(
    .CHANNELS (CHANNELS),
    .MODE     (MODE)
  ) u_arbiter (
    .Clock    (Clock),
    .Reset    (Reset),
    .eligible (eligible),
    .grant    (grant),
    .grantIdx (grantIdx),
    .anyGrant (anyGrant)
  );

  // Route the winning channel's address, data and direction.
  always_comb begin
    winAddr = bus.Select[grantIdx*M +: M];
    winData = bus.WData[grantIdx*N +: N];
    winRW   = bus.RW[grantIdx];
  end

  // Perform the granted access and register the acknowledge outputs.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int a = 0; a < COUNT; a++) mem[a] <= '0;
      ackReg        <= '0;
      rValidReg     <= 1'b0;
      rDataReg      <= '0;
      ackChannelReg <= '0;
    end else begin
      ackReg    <= grant;
      rValidReg <= anyGrant && (winRW == RW_READ);
      if (anyGrant) begin
        ackChannelReg <= grantIdx;
        if (winRW == RW_WRITE) begin
          mem[winAddr] <= winData;
        end else begin
          rDataReg <= mem[winAddr];
        end
      end
    end
  end

  assign bus.Ack        = ackReg;
  assign bus.RValid     = rValidReg;
  assign bus.RData      = rDataReg;
  assign bus.AckChannel = ackChannelReg;

endmodule

// File: tb/tb_arbitrated_memory.sv
// Bench for arbitrated_memory: a round-robin and a fixed-priority instance
// see identical stimulus; a reference model predicts each acknowledge.
module tb_arbitrated_memory;
  import arbitrated_memory_pkg::*;

  localparam int N  = 8;
  localparam int M  = 2;
  localparam int CH = 4;
  localparam int EW = 2 + 1 + N;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [CH-1:0]   req = '0;
  logic [CH-1:0]   rw  = '0;
  logic [CH*M-1:0] sel = '0;
  logic [CH*N-1:0] wd  = '0;

  arbitrated_memory_if #(.N(N), .M(M), .CHANNELS(CH)) bus0 ();
  arbitrated_memory_if #(.N(N), .M(M), .CHANNELS(CH)) bus1 ();

  assign bus0.Req = req;  assign bus1.Req = req;
  assign bus0.RW  = rw;   assign bus1.RW  = rw;
  assign bus0.Select = sel; assign bus1.Select = sel;
  assign bus0.WData  = wd;  assign bus1.WData  = wd;

  arbitrated_memory #(.N(N), .M(M), .CHANNELS(CH), .MODE(MODE_RR)) dut0 (
    .Clock (clk), .Reset (rst), .bus (bus0.slave)
  );
  arbitrated_memory #(.N(N), .M(M), .CHANNELS(CH), .MODE(MODE_FIXED)) dut1 (
    .Clock (clk), .Reset (rst), .bus (bus1.slave)
  );

  // ---------------- scoreboard ----------------
  logic [EW-1:0] exp_q0[$];
  logic [EW-1:0] exp_q1[$];
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Per instance: memory image, last winner (-1 none), rotation pointer,
  // and the read-data value currently being held.
  logic [N-1:0] mMem [2][1<<M];
  int           mLast [2];
  int           mPtr [2];
  logic [N-1:0] mRd [2];

  task automatic modelEdge(input int k);
    int win;
    int c;
    int a;
    logic [EW-1:0] e;
    if (rst) begin
      for (int i = 0; i < (1 << M); i++) mMem[k][i] = '0;
      mLast[k] = -1;
      mPtr[k]  = CH - 1;
      mRd[k]   = '0;
      return;
    end
    win = -1;
    for (int i = 1; i <= CH; i++) begin
      c = (k == 0) ? (mPtr[k] + i) % CH : i - 1;
      if (win < 0 && req[c] && mLast[k] != c) win = c;
    end
    mLast[k] = win;
    if (win < 0) return;
    if (k == 0) mPtr[k] = win;
    a = int'(sel[win*M +: M]);
    if (rw[win]) mMem[k][a] = wd[win*N +: N];
    else         mRd[k] = mMem[k][a];
    e = {2'(win), ~rw[win], mRd[k]};
    if (k == 0) exp_q0.push_back(e);
    else        exp_q1.push_back(e);
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic [CH-1:0] q, input logic [CH-1:0] w,
                      input logic [CH*M-1:0] s, input logic [CH*N-1:0] d);
    rst = r; req = q; rw = w; sel = s; wd = d;
    modelEdge(0);
    modelEdge(1);
    @(posedge clk);
    #1;
  endtask

  // ---------------- monitor ----------------
  task automatic monitorOne(input int k, input logic [CH-1:0] ack, input logic rv,
                            input logic [N-1:0] rd, input logic [1:0] ac);
    logic [EW-1:0] e;
    if (ack != '0) begin
      if ((k == 0 && exp_q0.size() == 0) || (k == 1 && exp_q1.size() == 0)) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack dut%0d: got %b expected none at %0t", k, ack, $time);
      end else begin
        e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        check($sformatf("ack_vec%0d", k), 32'(ack), 32'(4'b0001 << e[EW-1 -: 2]));
        check($sformatf("ack_chan%0d", k), 32'(ac), 32'(e[EW-1 -: 2]));
        check($sformatf("rvalid%0d", k), 32'(rv), 32'(e[N]));
        check($sformatf("rdata%0d", k), 32'(rd), 32'(e[N-1:0]));
      end
    end
  endtask

  always @(negedge clk) begin
    monitorOne(0, bus0.Ack, bus0.RValid, bus0.RData, bus0.AckChannel);
    monitorOne(1, bus1.Ack, bus1.RValid, bus1.RData, bus1.AckChannel);
  end

  // ---------------- stimulus ----------------
  initial begin
    // Reset with every channel requesting: nothing may be acknowledged.
    step(1'b1, 4'hF, 4'hF, 8'hE4, 32'hFFFF_FFFF);
    step(1'b1, 4'hF, 4'hF, 8'hE4, 32'hFFFF_FFFF);
    check("rst_ack0", 32'(bus0.Ack), 0);
    check("rst_ack1", 32'(bus1.Ack), 0);
    check("rst_rvalid0", 32'(bus0.RValid), 0);
    check("rst_rdata0", 32'(bus0.RData), 0);
    check("rst_chan0", 32'(bus0.AckChannel), 0);
    check("rst_rdata1", 32'(bus1.RData), 0);

    // Every address reads zero after reset.
    for (int a = 0; a < 4; a++) begin
      step(1'b0, 4'b0001, 4'b0000, 8'(a), '0);
      step(1'b0, 4'b0000, 4'b0000, 8'(a), '0);
    end

    // Write then read back on the next available edge.
    step(1'b0, 4'b0001, 4'b0001, 8'd2, 32'h0000_00A5);
    step(1'b0, 4'b0001, 4'b0000, 8'd2, '0);
    step(1'b0, 4'b0001, 4'b0000, 8'd2, '0);
    step(1'b0, 4'b0000, 4'b0000, 8'd0, '0);

    // Preload 10..13, then all four channels read their own address.
    for (int a = 0; a < 4; a++) begin
      step(1'b0, 4'b0001, 4'b0001, 8'(a), 32'(8'h10 + a));
      step(1'b0, 4'b0000, 4'b0000, 8'd0, '0);
    end
    for (int i = 0; i < 12; i++) step(1'b0, 4'hF, 4'h0, 8'b11_10_01_00, '0);
    step(1'b0, 4'h0, 4'h0, 8'd0, '0);

    // Channels 1 and 3 continuously, then channel 0 joins.
    for (int i = 0; i < 8; i++) step(1'b0, 4'b1010, 4'h0, 8'b11_10_01_00, '0);
    for (int i = 0; i < 8; i++) step(1'b0, 4'b1011, 4'h0, 8'b11_10_01_00, '0);
    step(1'b0, 4'h0, 4'h0, 8'd0, '0);

    // Same-edge conflict straight out of reset: ch2 writes addr 1, ch3 reads it.
    step(1'b1, 4'h0, 4'h0, 8'd0, '0);
    for (int i = 0; i < 3; i++) step(1'b0, 4'b1100, 4'b0100, 8'b01_01_00_00, 32'h003C_0000);
    step(1'b0, 4'h0, 4'h0, 8'd0, '0);

    // Reset lands on the edge a write to addr 3 would be granted.
    step(1'b1, 4'b0001, 4'b0001, 8'd3, 32'h0000_00FF);
    step(1'b0, 4'b0001, 4'b0000, 8'd3, '0);
    step(1'b0, 4'b0000, 4'b0000, 8'd3, '0);

    // Randomised traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 49) == 0), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
           8'($urandom_range(0, 255)), 32'($urandom));
    end

    // Drain and confirm every predicted acknowledge was seen.
    for (int i = 0; i < 3; i++) step(1'b0, 4'h0, 4'h0, 8'd0, '0);
    check("queue0_drained", 32'(exp_q0.size()), 0);
    check("queue1_drained", 32'(exp_q1.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
